// File: rtl/adc_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC sample sequencer slice.
//   seq_state_e          : sequencer FSM encoding (IDLE, START, WAIT)
//   RESULT_W             : width of one ADC conversion result
//   DEFAULT_FIFO_DEPTH   : default number of buffered results
//   DEFAULT_TIMEOUT_CYC  : default watchdog limit, in cycles spent in WAIT
// -----------------------------------------------------------------------------
package adc_seq_pkg;

    localparam int RESULT_W            = 16;
    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int DEFAULT_TIMEOUT_CYC = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/adc_result_fifo.sv
// -----------------------------------------------------------------------------
// adc_result_fifo
// Synchronous first-word-fall-through FIFO holding ADC results.
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push_in        : write push_data_in this cycle (ignored when full unless
//                    a pop happens in the same cycle)
//   push_data_in   : data to write
//   pop_in         : consume the head (ignored when empty)
//   head_out       : current head, forced to 0 while empty
//   valid_out      : FIFO holds at least one entry
//   full_out       : FIFO holds DEPTH entries
//   level_out      : number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module adc_result_fifo
    import adc_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = RESULT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         push_data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         head_out,
    output logic                     valid_out,
    output logic                     full_out,
    output logic [$clog2(DEPTH):0]   level_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty, full, do_push, do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop. Pointers wrap naturally because
    // DEPTH is a power of two; the level counter disambiguates full/empty.
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_W'(DEPTH));
        do_pop   = pop_in && !empty;
        do_push  = push_in && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because the head is masked
    // while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= push_data_in;
        end
    end

    assign head_out  = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_out = !empty;
    assign full_out  = full;
    assign level_out = level_q;

endmodule

// File: rtl/adc_sample_sequencer.sv
// -----------------------------------------------------------------------------
// adc_sample_sequencer
// Issues ADC start pulses (periodic or single-shot), waits for the finish
// strobe, buffers results in a FWFT FIFO and reports dropped results and
// hung conversions through sticky flags.
//   clk, rst                : clock, synchronous active-high reset
//   enable_in, period_in    : periodic mode enable and start-to-start spacing
//   single_shot_in          : one-cycle request for one conversion (IDLE only)
//   clear_flags_in          : clears overflow_out and timeout_out
//   start_conversion_out    : one-cycle registered start pulse to the ADC
//   result_in, conversion_finished_in : ADC result and its done strobe
//   data_out, data_valid_out, data_ready_in : FIFO head and handshake
//   fifo_level_out          : occupied FIFO entries
//   busy_out                : sequencer is not IDLE
//   overflow_out            : sticky, a result was dropped (FIFO full)
//   timeout_out             : sticky, a conversion was aborted by the watchdog
// -----------------------------------------------------------------------------
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_in,
    input  logic                         single_shot_in,
    input  logic [15:0]                  period_in,
    input  logic                         clear_flags_in,
    output logic                         start_conversion_out,
    input  logic [RESULT_W-1:0]          result_in,
    input  logic                         conversion_finished_in,
    output logic [RESULT_W-1:0]          data_out,
    output logic                         data_valid_out,
    input  logic                         data_ready_in,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_out,
    output logic                         busy_out,
    output logic                         overflow_out,
    output logic                         timeout_out
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    seq_state_e  state_q, state_d;
    logic        start_q, start_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] wd_q, wd_d;
    logic        overflow_q, overflow_d;
    logic        timeout_q, timeout_d;

    logic        trigger, fifo_push, fifo_pop, fifo_full;
    logic        set_overflow, set_timeout;

    // Next-state logic for the sequencer, period timer and watchdog.
    // The period timer is loaded on the edge that enters START with
    // period_in-1: the trigger cycle itself is the first cycle of the period,
    // which makes consecutive START pulses exactly period_in cycles apart.
    // A finish in the last watchdog cycle still counts as a normal finish.
    always_comb begin
        trigger      = (enable_in && (timer_q == '0)) || single_shot_in;
        fifo_pop     = data_valid_out && data_ready_in;
        state_d      = state_q;
        start_d      = 1'b0;
        timer_d      = (timer_q != '0) ? timer_q - 16'd1 : '0;
        wd_d         = wd_q;
        fifo_push    = 1'b0;
        set_overflow = 1'b0;
        set_timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                    timer_d = (period_in == '0) ? '0 : period_in - 16'd1;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                wd_d    = '0;
            end
            ST_WAIT: begin
                if (conversion_finished_in) begin
                    state_d      = ST_IDLE;
                    fifo_push    = 1'b1;
                    set_overflow = fifo_full && !fifo_pop;
                end else if (wd_q == WD_LAST) begin
                    state_d     = ST_IDLE;
                    set_timeout = 1'b1;
                    wd_d        = '0;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A set event in the same cycle as a clear keeps the flag high.
        overflow_d = set_overflow || (overflow_q && !clear_flags_in);
        timeout_d  = set_timeout  || (timeout_q  && !clear_flags_in);
    end

    // All sequencer state registers, including the registered start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            timer_q    <= '0;
            wd_q       <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            timer_q    <= timer_d;
            wd_q       <= wd_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    adc_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_in      (fifo_push),
        .push_data_in (result_in),
        .pop_in       (fifo_pop),
        .head_out     (data_out),
        .valid_out    (data_valid_out),
        .full_out     (fifo_full),
        .level_out    (fifo_level_out)
    );

    assign start_conversion_out = start_q;
    assign busy_out             = (state_q != ST_IDLE);
    assign overflow_out         = overflow_q;
    assign timeout_out          = timeout_q;

endmodule
